// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: opcodes, XLEN, load/store width
// codes, and the data-memory responder FSM encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Load/store width codes (func3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Data-memory responder FSM
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_RESP = 2'd2
    } mem_state_e;

    localparam int CNT_W = 4;

    // Stores only have the signed-width codes; loads add BU/HU.
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!wr)
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and lane
// shift, and load lane extraction with sign/zero extension.
//   func3/addr_lo : access width and byte offset
//   st_data/st_be/st_word : right-aligned store data -> lanes
//   ld_word/ld_data : raw storage word -> extended load result
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  st_be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_sh;

    always_comb begin
        st_word = st_data << {addr_lo, 3'b000};
        ld_sh   = ld_word >> {addr_lo, 3'b000};

        st_be = 4'b0000;
        unique case (func3[1:0])
            2'b00:   st_be = 4'b0001 << addr_lo;
            2'b01:   st_be = 4'b0011 << {addr_lo[1], 1'b0};
            2'b10:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase

        ld_data = 32'h0;
        unique case (func3)
            F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            F3_BU:   ld_data = {24'h0, ld_sh[7:0]};
            F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            F3_HU:   ld_data = {16'h0, ld_sh[15:0]};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response
// pair with configurable wait states and error reporting.
//   clk, reset (sync, active-low)
//   req_* : request channel, rsp_* : response channel
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live_q, live_d;
    logic             write_q, write_d;
    logic [2:0]       func3_q, func3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept;
    logic             enter_resp;
    logic             cur_write;
    logic [2:0]       cur_func3;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic [IDX_W-1:0] idx;
    logic [3:0]       st_be;
    logic [31:0]      st_word;
    logic [31:0]      ld_data;
    logic             wr_en;

    // live_q keeps req_ready low until the first edge out of reset.
    assign req_ready = live_q && (state_q == MS_IDLE);
    assign rsp_valid = (state_q == MS_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    // With zero wait states RESP is entered straight from IDLE, before
    // the captured copy exists, so the live inputs are used there.
    always_comb begin
        if (state_q == MS_IDLE) begin
            cur_write = req_write;
            cur_func3 = req_func3;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_write = write_q;
            cur_func3 = func3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        cur_err = !f3_legal(cur_write, cur_func3);
        if (cur_func3[1:0] == 2'b01 && cur_addr[0])
            cur_err = 1'b1;
        if (cur_func3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00)
            cur_err = 1'b1;
        if (|cur_addr[31:IDX_W+2])
            cur_err = 1'b1;
    end

    assign idx = cur_addr[IDX_W+1:2];

    mem_lane_align u_align (
        .func3   (cur_func3),
        .addr_lo (cur_addr[1:0]),
        .st_data (cur_wdata),
        .ld_word (mem_q[idx]),
        .st_be   (st_be),
        .st_word (st_word),
        .ld_data (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        live_d     = 1'b1;
        write_d    = write_q;
        func3_d    = func3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        unique case (state_q)
            MS_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = MS_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = MS_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            MS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = MS_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MS_RESP: begin
                if (rsp_ready)
                    state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase

        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_write || cur_err) ? 32'h0 : ld_data;
        end
    end

    assign wr_en = enter_resp && cur_write && !cur_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            write_q <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
            write_q <= write_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is never cleared; reset only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b])
                    mem_q[idx][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder
// (DEPTH_WORDS=256, WAIT_CYCLES=1).
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_err    = 0;

    data_mem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; rsp_ready is assumed 1 so the response
    // handshakes on its first cycle.
    task automatic do_req(input string tag, input logic w,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d,
                          input logic exp_e);
        int lat;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_write = w;
        req_func3 = f3;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        tick();
    endtask

    initial begin
        logic [31:0] hold_d;
        logic        hold_e;
        int          lat;

        reset     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;

        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_rel_ready", 32'(req_ready), 32'd1);

        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0);
        do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
        do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        do_req("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
        do_req("sw12", 1'b1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1'b1);
        do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        do_req("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
        do_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req("st100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h000080AD, 1'b0);
        do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 1'b0);
        do_req("lb11", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
        do_req("sh12", 1'b1, 3'b001, 32'h12, 32'h5AA5, 32'h0, 1'b0);
        do_req("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 32'h5AA5BEEF, 1'b0);
        do_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
        do_req("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);

        // Back-pressure: response must hold while rsp_ready=0.
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        tick();
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("hold_lat", 32'(lat), 32'd2);
        hold_d = rsp_rdata;
        hold_e = rsp_err;
        check("hold_rdata0", hold_d, 32'h5AA5BEEF);
        req_addr = 32'h3FC;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, hold_d);
            check("hold_err", 32'(rsp_err), 32'(hold_e));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("rel_valid", 32'(rsp_valid), 32'd0);
        check("rel_ready", 32'(req_ready), 32'd1);

        // Reset during WAIT aborts the store.
        do_req("sw20old", 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        req_write = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("abort_in_wait", 32'(rsp_valid | req_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("abort_rst_ready", 32'(req_ready), 32'd0);
        check("abort_rst_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        tick();
        check("abort_rel_ready", 32'(req_ready), 32'd1);
        do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

        // Reset during RESP drops the response.
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h20;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("drop_valid_pre", 32'(rsp_valid), 32'd1);
        reset = 1'b0;
        tick();
        check("drop_valid", 32'(rsp_valid), 32'd0);
        check("drop_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check("drop_rel_ready", 32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit storage words (power of two, 16..4096).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the number of wait states between request accept and response (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate that the initiator presents a request.
REQ-006 req_ready  output  1  SHALL indicate that the responder accepts a request this cycle.
REQ-007 req_write  input  1  SHALL select a store when 1 and a load when 0.
REQ-008 req_func3  input  3  SHALL carry the RV32I load/store width code.
REQ-009 req_addr  input  32  SHALL carry the byte address.
REQ-010 req_wdata  input  32  SHALL carry store data, with the valid bytes right-aligned.
REQ-011 rsp_valid  output  1  SHALL indicate that a response is presented.
REQ-012 rsp_ready  input  1  SHALL indicate that the initiator accepts the response.
REQ-013 rsp_rdata  output  32  SHALL carry load data after extension; it SHALL be 0 for stores and errors.
REQ-014 rsp_err  output  1  SHALL flag a misaligned, out-of-range or illegal-func3 request.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL equal (state==IDLE).
REQ-017 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; all req_* inputs SHALL be captured into internal registers on that cycle.
REQ-018 On accept, the FSM SHALL go IDLE->WAIT when WAIT_CYCLES>0 and IDLE->RESP otherwise.
REQ-019 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL move the FSM to RESP on the cycle after it reaches 0.
REQ-020 rsp_valid SHALL equal (state==RESP); rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-021 RESP SHALL go to IDLE on rsp_valid && rsp_ready; no new request SHALL be accepted in that same cycle.
REQ-022 Latency from accept to first rsp_valid=1 SHALL be WAIT_CYCLES+1 cycles.
REQ-023 Legal load func3 codes SHALL be 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal store codes SHALL be 000 SB, 001 SH and 010 SW. Any other code SHALL set rsp_err.
REQ-024 Misalignment SHALL set rsp_err: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-025 A word index, addr[31:2], >= DEPTH_WORDS SHALL set rsp_err (no wrap-around).
REQ-026 A store SHALL commit through byte enables on the cycle the FSM enters RESP, and only when the request is error-free.
REQ-027 Byte-enable and data lane selection SHALL use addr[1:0]: SB writes byte addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes.
REQ-028 Load data SHALL be the selected lane right-shifted; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-029 A load SHALL read the storage value at RESP entry, so a store completed earlier is always visible to the load that follows it.
REQ-030 Erroneous requests SHALL still complete the handshake with the normal latency.

Reset
REQ-031 While reset=0 at a clock edge, the block SHALL set state=IDLE, the counter to 0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and req_ready=0. req_ready SHALL become 1 in the first cycle after reset=1 is sampled.
REQ-032 Reset asserted in WAIT SHALL abort the transaction with no storage write; reset asserted in RESP SHALL drop the response.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-034 The func3 codes, the FSM state encoding and the 4-bit wait-counter width SHALL live in the shared riscv package, alongside the existing core definitions.
REQ-035 Lane selection and extension logic SHALL be a combinational sub-module named mem_lane_align, used for both the store and load paths.

Verification
REQ-036 With WAIT_CYCLES=1: SW 0xDEADBEEF to 0x10, then LW from 0x10 -> rsp_valid at accept+2, rdata=0xDEADBEEF, err=0.
REQ-037 SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-038 LH from 0x11 -> err=1, rdata=0; SW to 0x12 -> err=1, and a following LW 0x10 is unchanged.
REQ-039 Address 0x400 (DEPTH 256), or func3=011 -> err=1 with the handshake completing normally.
REQ-040 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable and req_ready=0; then rsp_ready=1 -> IDLE next cycle.
REQ-041 Assert reset in WAIT during SW 0x12345678 to 0x20 -> the following LW 0x20 returns the old value; req_ready=1 in the first cycle after reset=1 is sampled.
